// File: rtl/terminate_pkg.sv
//------------------------------------------------------------------------------
// Module : terminate_pkg
// Brief  : Opcodes, address modes and bit positions for the terminate stage.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package terminate_pkg;

  localparam logic [3:0] OP_TERM_UNCOND = 4'hF;
  localparam logic [3:0] OP_TERM_COND   = 4'hE;
  localparam int         POL_BIT        = 3;

  typedef enum logic [1:0] {
    MODE_REL  = 2'b00,
    MODE_IND  = 2'b01,
    MODE_PAGE = 2'b10,
    MODE_ZP   = 2'b11
  } addr_mode_e;

  // flag_index[3] forces the condition true, otherwise it picks one flag bit.
  function automatic logic cond_select(input logic [3:0] idx, input logic [7:0] flags);
    return idx[3] ? 1'b1 : flags[idx[2:0]];
  endfunction

endpackage

`default_nettype wire

// File: rtl/terminate_addr_gen.sv
//------------------------------------------------------------------------------
// Module : terminate_addr_gen
// Brief  : Combinational redirect address mux/adder (all arithmetic mod 2^16).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module terminate_addr_gen
  import terminate_pkg::*;
(
  input  logic [15:0] reg_base_val,
  input  logic [7:0]  offset,
  input  addr_mode_e  mode,
  output logic [15:0] addr
);

  always_comb begin
    addr = 16'h0000;
    case (mode)
      MODE_REL:  addr = reg_base_val + {{8{offset[7]}}, offset};
      MODE_IND:  addr = reg_base_val;
      MODE_PAGE: addr = {reg_base_val[15:8], offset};
      MODE_ZP:   addr = {8'h00, offset};
      default:   addr = 16'h0000;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/terminate_pipeline.sv
//------------------------------------------------------------------------------
// Module : terminate_pipeline
// Brief  : Resolves terminate ops into a registered redirect address and taken
//          strobe. TERMINATE_EXTRA_STAGE_EN adds a second output register stage.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module terminate_pipeline
  import terminate_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic [15:0] reg_base_val,
  input  logic [3:0]  flag_index,
  input  logic [7:0]  flag_vals,
  input  logic [7:0]  offset,
  input  logic [3:0]  immediate,
  output logic [15:0] result_addr,
  output logic        result_valid
);

  logic [15:0] calc_addr;
  logic        cond;
  logic        taken;
  logic        result_valid_d, result_valid_q;
  logic [15:0] result_addr_d,  result_addr_q;

  // immediate[2] is reserved and intentionally has no effect on the outputs.
  logic unused_imm_rsvd;
  assign unused_imm_rsvd = immediate[2];

  terminate_addr_gen u_addr_gen (
    .reg_base_val (reg_base_val),
    .offset       (offset),
    .mode         (addr_mode_e'(immediate[1:0])),
    .addr         (calc_addr)
  );

  always_comb begin
    cond  = cond_select(flag_index, flag_vals);
    taken = 1'b0;
    if (opcode == OP_TERM_UNCOND) begin
      taken = 1'b1;
    end else if (opcode == OP_TERM_COND) begin
      taken = immediate[POL_BIT] ? ~cond : cond;
    end
    result_valid_d = taken;
    result_addr_d  = taken ? calc_addr : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid_q <= 1'b0;
      result_addr_q  <= 16'h0000;
    end else begin
      result_valid_q <= result_valid_d;
      result_addr_q  <= result_addr_d;
    end
  end

`ifdef TERMINATE_EXTRA_STAGE_EN
  logic        stage2_valid_d, stage2_valid_q;
  logic [15:0] stage2_addr_d,  stage2_addr_q;

  always_comb begin
    stage2_valid_d = result_valid_q;
    stage2_addr_d  = result_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage2_valid_q <= 1'b0;
      stage2_addr_q  <= 16'h0000;
    end else begin
      stage2_valid_q <= stage2_valid_d;
      stage2_addr_q  <= stage2_addr_d;
    end
  end

  assign result_valid = stage2_valid_q;
  assign result_addr  = stage2_addr_q;
`else
  assign result_valid = result_valid_q;
  assign result_addr  = result_addr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_terminate_pipeline.sv
//------------------------------------------------------------------------------
// Module : tb_terminate_pipeline
// Brief  : Self-checking bench for terminate_pipeline with a behavioural model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_terminate_pipeline;

`ifdef TERMINATE_EXTRA_STAGE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic [15:0] reg_base_val;
  logic [3:0]  flag_index;
  logic [7:0]  flag_vals;
  logic [7:0]  offset;
  logic [3:0]  immediate;
  logic [15:0] result_addr;
  logic        result_valid;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic        exp_v [0:1];
  logic [15:0] exp_a [0:1];

  terminate_pipeline dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .reg_base_val (reg_base_val),
    .flag_index   (flag_index),
    .flag_vals    (flag_vals),
    .offset       (offset),
    .immediate    (immediate),
    .result_addr  (result_addr),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  // Reference: outputs derived directly from the ISA-level rules.
  function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] base,
                                        input logic [3:0] idx, input logic [7:0] flags,
                                        input logic [7:0] off, input logic [3:0] imm);
    int   a;
    logic c, tk;
    logic [15:0] r;
    c  = idx[3] ? 1'b1 : flags[idx[2:0]];
    tk = (op == 4'hF) ? 1'b1 : (op == 4'hE) ? (imm[3] ? !c : c) : 1'b0;
    case (imm[1:0])
      2'd0:    a = int'(base) + ((off >= 8'd128) ? int'(off) - 256 : int'(off));
      2'd1:    a = int'(base);
      2'd2:    a = (int'(base) / 256) * 256 + int'(off);
      default: a = int'(off);
    endcase
    a = a & 32'h0000FFFF;
    r = a[15:0];
    return tk ? {1'b1, r} : 17'h0;
  endfunction

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      exp_v[i] = 1'b0;
      exp_a[i] = 16'h0000;
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] base, input logic [3:0] idx,
                       input logic [7:0] flags, input logic [7:0] off, input logic [3:0] imm);
    opcode = op; reg_base_val = base; flag_index = idx;
    flag_vals = flags; offset = off; immediate = imm;
  endtask

  // One cycle: drive at negedge, advance model at posedge, compare at next negedge.
  task automatic step(input logic [3:0] op, input logic [15:0] base, input logic [3:0] idx,
                      input logic [7:0] flags, input logic [7:0] off, input logic [3:0] imm);
    logic [16:0] m;
    drive(op, base, idx, flags, off, imm);
    m = model(op, base, idx, flags, off, imm);
    @(posedge clk);
    exp_v[1] = exp_v[0]; exp_a[1] = exp_a[0];
    exp_v[0] = m[16];    exp_a[0] = m[15:0];
    @(negedge clk);
    chk("model", {result_valid, result_addr}, {exp_v[LAT-1], exp_a[LAT-1]});
  endtask

  task automatic directed(input string name, input logic [3:0] op, input logic [15:0] base,
                          input logic [3:0] idx, input logic [7:0] flags, input logic [7:0] off,
                          input logic [3:0] imm, input logic ev, input logic [15:0] ea);
    step(op, base, idx, flags, off, imm);
    for (int i = 1; i < LAT; i++) step(4'h0, 16'h0, 4'h0, 8'h0, 8'h0, 4'h0);
    chk(name, {result_valid, result_addr}, {ev, ea});
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0;
    drive(4'hF, 16'h1234, 4'h0, 8'h00, 8'h00, 4'h1);
    #12;
    chk("reset_state", {result_valid, result_addr}, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;

    directed("uncond_rel",   4'hF, 16'h1000, 4'h0, 8'h00, 8'hFE, 4'h0, 1'b1, 16'h0FFE);
    directed("uncond_zp",    4'hF, 16'h1000, 4'h0, 8'h00, 8'h42, 4'h3, 1'b1, 16'h0042);
    directed("cond_set_hit", 4'hE, 16'h1000, 4'h2, 8'h04, 8'h00, 4'h0, 1'b1, 16'h1000);
    directed("cond_set_miss",4'hE, 16'h1000, 4'h3, 8'h04, 8'h00, 4'h0, 1'b0, 16'h0000);
    directed("cond_clr_miss",4'hE, 16'h1000, 4'h2, 8'h04, 8'h00, 4'h8, 1'b0, 16'h0000);
    directed("cond_clr_page",4'hE, 16'h12F0, 4'h1, 8'h04, 8'h34, 4'hA, 1'b1, 16'h1234);
    directed("wrap_up",      4'hF, 16'hFFFF, 4'h0, 8'h00, 8'h01, 4'h0, 1'b1, 16'h0000);
    directed("wrap_down",    4'hF, 16'h0000, 4'h0, 8'h00, 8'h80, 4'h0, 1'b1, 16'hFF80);
    directed("const_clr",    4'hE, 16'h5555, 4'h8, 8'h00, 8'h11, 4'h8, 1'b0, 16'h0000);
    directed("const_set",    4'hE, 16'h5555, 4'h8, 8'h00, 8'h11, 4'h1, 1'b1, 16'h5555);
    directed("noop",         4'h3, 16'hABCD, 4'h8, 8'hFF, 8'h77, 4'h3, 1'b0, 16'h0000);
    directed("rsvd_bit",     4'hF, 16'h2000, 4'h0, 8'h00, 8'h10, 4'h4, 1'b1, 16'h2010);
    directed("indirect",     4'hF, 16'hBEEF, 4'h0, 8'h00, 8'h99, 4'h1, 1'b1, 16'hBEEF);

    // back-to-back randomized ops
    for (int n = 0; n < 600; n++) begin
      logic [3:0] op;
      case ($urandom_range(0, 3))
        0:       op = 4'hF;
        1:       op = 4'hE;
        default: op = 4'($urandom);
      endcase
      step(op, 16'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
    end

    // asynchronous reset mid-stream with a taken op in flight
    drive(4'hF, 16'h4000, 4'h0, 8'h00, 8'h05, 4'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {result_valid, result_addr}, 17'h0);
    clear_model();
    @(negedge clk);
    drive(4'hF, 16'h7777, 4'h0, 8'h00, 8'h00, 4'h1);
    @(posedge clk);
    @(negedge clk);
    chk("held_reset", {result_valid, result_addr}, 17'h0);
    drive(4'h0, 16'h0, 4'h0, 8'h00, 8'h00, 4'h0);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 1; i++) step(4'h0, 16'h7777, 4'h8, 8'hFF, 8'h00, 4'h1);
    chk("post_reset_idle", {result_valid, result_addr}, 17'h0);
    directed("post_reset_op", 4'hF, 16'h3000, 4'h0, 8'h00, 8'h7F, 4'h0, 1'b1, 16'h307F);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
